prio_arb_rr: RTL and testbench
==============================

Name: prio_arb_rr

Overview:
- Parametrised, registered N-input priority encoder/arbiter.
- Successor to the 4-input combinational OR/valid encoder: generalised width, runtime selectable fixed or round-robin priority, and a valid/ack hold handshake.
- Sits between request sources and a single shared consumer (bus or port) and issues one grant at a time.

Parameters:
- N, 8, number of request inputs (N >= 2).
- IDX_W, $clog2(N), width of the encoded index (derived; not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- req  input  N  request vector; bit i = requester i.
- en  input  1  arbitration enable; no new grant is issued while low.
- rr_en  input  1  1 = round-robin priority, 0 = fixed priority (index 0 highest). Sampled at each arbitration.
- ack  input  1  consumer accepts the current grant.
- valid  output  1  a grant is being presented.
- idx  output  IDX_W  binary index of the granted requester.
- gnt  output  N  one-hot grant; all zeros when valid=0.

Behaviour:
- Reset: on a clk edge with rst_n=0: valid=0, idx=0, gnt=0, rr pointer ptr=0, FSM=IDLE. Reset mid-HOLD drops the grant at that edge with no ack required.
- All outputs are registered. There is no combinational path from req, en or ack to any output.
- FSM, IDLE state:
  - valid=0.
  - If en=1 and |req=1 at an edge: latch the winner, go to HOLD. valid=1 from the next cycle (1-cycle latency).
  - Otherwise stay in IDLE.
- FSM, HOLD state:
  - valid=1; idx and gnt are frozen.
  - Grant is sticky: changes to req, en or rr_en do not alter the presented idx or gnt.
- FSM, ack while in HOLD:
  - With en=1 and any req bit set (including the just-served bit), load the next winner at the same edge and stay in HOLD. This gives back-to-back grants with no bubble.
  - Otherwise go to IDLE; valid=0 next cycle.
  - ack while valid=0 is ignored.
- Winner selection, fixed mode (rr_en=0): lowest set index of req.
- Winner selection, round-robin mode (rr_en=1):
  - Search from ptr upward; wrap from N-1 to 0.
  - The first set bit wins.
  - ptr is not consulted in fixed mode.
- ptr update:
  - On each accepted grant (ack while valid=1) in rr mode, ptr <= idx+1. If idx=N-1, ptr <= 0.
  - In fixed mode ptr holds its value.
- Invariant: gnt == (1 << idx) whenever valid=1. gnt is never non-one-hot.
- The arbitration input for back-to-back grants is req at the ack edge. The served requester must deassert before that edge if it has no further work.

Decomposition:
- Shared package prio_pkg: FSM state enum (IDLE, HOLD) and a function for the index width, with a minimum of 1.
- One natural sub-module, prio_find_first: combinational N-bit "first set bit at or above start, with wrap" finder.
  - Inputs: vector, start index.
  - Outputs: found flag, index.
  - Fixed mode reuses it with start=0.

Test Plan:
- Reset/idle: rst_n=0 for 2 cycles with req=8'hFF -> valid=0, gnt=0, idx=0 throughout; release with req=0 -> valid stays 0.
- Fixed priority: N=8, rr_en=0, en=1, req=8'b1010_1000 -> one cycle later valid=1, idx=3, gnt=8'h08. The grant holds across 5 cycles without ack even when req changes to 8'h80. Pulse ack with req=8'h80 -> next cycle idx=7, valid=1.
- Round-robin fairness: rr_en=1, req=8'hFF held, ack every cycle -> idx sequence 0,1,2,...,7,0 with valid continuously 1.
- RR wrap/skip: ptr=6 (after granting 5), req=8'b0000_0101 -> idx=0. Ack -> ptr=1; next grant idx=2.
- Handshake drop: grant idx=2, then en=0 at the ack edge -> valid=0 next cycle, gnt=0. Re-raise en -> new grant after exactly 1 cycle.
- Reset mid-operation: valid=1, idx=4, rr ptr=5; assert rst_n=0 for 1 cycle -> valid=0, ptr=0. Next grant with req=8'h30 in rr mode -> idx=4.

Source files
------------

// File: rtl/prio_pkg.sv
// Shared types and helpers for the registered priority / round-robin arbiter.
package prio_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Encoded index width; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_find_first.sv
// First set bit of vec at or above start, wrapping from N-1 back to 0.
module prio_find_first
  import prio_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     vec,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  int j;

  // Walk the circular order downward so the nearest set bit is the last write.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(start) + k;
      if (j >= N) j = j - N;
      if (vec[j]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/prio_arb_rr.sv
// Registered N-input arbiter: fixed or round-robin priority, sticky grant held
// until ack, back-to-back re-arbitration on the ack edge.
module prio_arb_rr
  import prio_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = idx_w(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             en,
  input  logic             rr_en,
  input  logic             ack,
  output logic             valid,
  output logic [IDX_W-1:0] idx,
  output logic [N-1:0]     gnt
);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, idx_inc, start, win;
  logic             found, accept, load, drop;

  assign accept  = (state == HOLD) && ack;
  assign idx_inc = (idx == IDX_W'(N - 1)) ? '0 : idx + IDX_W'(1);

  // On an rr accept the pointer moves this edge, so search from its new value.
  assign start = !rr_en ? '0 : (accept ? idx_inc : ptr);

  prio_find_first #(.N(N), .IDX_W(IDX_W)) u_find (
    .vec   (req),
    .start (start),
    .found (found),
    .idx   (win)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        if (en && found) begin
          load      = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (ack) begin
          if (en && found) begin
            load = 1'b1;
          end else begin
            drop      = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      gnt   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        idx <= win;
        gnt <= {{(N-1){1'b0}}, 1'b1} << win;
      end else if (drop) begin
        gnt <= '0;
      end
      if (accept && rr_en) ptr <= idx_inc;
    end
  end

  assign valid = (state == HOLD);

endmodule

// File: tb/tb_prio_arb_rr.sv
// Scoreboard bench for prio_arb_rr: reference model pushes expected outputs per cycle.
module tb_prio_arb_rr;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n, en, rr_en, ack, valid;
  logic [N-1:0] req, gnt;
  logic [2:0]   idx;

  typedef struct packed {
    logic         v;
    logic [2:0]   i;
    logic [N-1:0] g;
  } exp_t;

  exp_t q[$];
  int   nvec = 0, nbad = 0;
  int   m_valid = 0, m_idx = 0, m_ptr = 0;

  always #5 clk = ~clk;

  prio_arb_rr #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .en    (en),
    .rr_en (rr_en),
    .ack   (ack),
    .valid (valid),
    .idx   (idx),
    .gnt   (gnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int s);
    for (int k = 0; k < N; k++)
      if (r[(s + k) % N]) return (s + k) % N;
    return -1;
  endfunction

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic step(input logic r_n, input logic [N-1:0] r, input logic e,
                      input logic rr, input logic a);
    exp_t ex, got;
    rst_n = r_n; req = r; en = e; rr_en = rr; ack = a;
    if (!r_n) begin
      m_valid = 0; m_idx = 0; m_ptr = 0;
    end else if (m_valid == 0) begin
      if (e && r != '0) begin
        m_idx = pick(r, rr ? m_ptr : 0);
        m_valid = 1;
      end
    end else if (a) begin
      if (rr) m_ptr = (m_idx + 1) % N;
      if (e && r != '0) m_idx = pick(r, rr ? m_ptr : 0);
      else m_valid = 0;
    end
    ex.v = (m_valid != 0);
    ex.i = 3'(m_idx);
    ex.g = ex.v ? (N'(1) << m_idx) : '0;
    q.push_back(ex);
    @(posedge clk);
    #1;
    got = q.pop_front();
    chk("valid", 32'(valid), 32'(got.v));
    chk("gnt", 32'(gnt), 32'(got.g));
    if (got.v) chk("idx", 32'(idx), 32'(got.i));
  endtask

  initial begin
    rst_n = 1'b0; req = '0; en = 1'b0; rr_en = 1'b0; ack = 1'b0;

    // reset with all requests asserted
    step(0, 8'hFF, 1, 0, 0);
    step(0, 8'hFF, 1, 0, 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_idx", 32'(idx), 0);
    chk("rst_gnt", 32'(gnt), 0);
    step(1, 8'h00, 1, 0, 0);
    chk("idle_valid", 32'(valid), 0);

    // fixed priority, sticky grant
    step(1, 8'b1010_1000, 1, 0, 0);
    chk("fx_idx", 32'(idx), 3);
    chk("fx_gnt", 32'(gnt), 32'h08);
    for (int k = 0; k < 5; k++) begin
      step(1, 8'h80, (k != 2), k[0], 0);
      chk("fx_hold", 32'(idx), 3);
    end
    step(1, 8'h80, 1, 0, 1);
    chk("fx_next", 32'(idx), 7);
    chk("fx_nextv", 32'(valid), 1);

    // round-robin fairness, ack every cycle
    for (int k = 0; k < 9; k++) begin
      step(1, 8'hFF, 1, 1, 1);
      chk("rr_seq", 32'(idx), 32'(k % 8));
      chk("rr_v", 32'(valid), 1);
    end
    for (int k = 1; k <= 5; k++) step(1, 8'hFF, 1, 1, 1);
    chk("rr_at5", 32'(idx), 5);

    // wrap and skip
    step(1, 8'b0000_0101, 1, 1, 1);
    chk("rr_wrap", 32'(idx), 0);
    step(1, 8'b0000_0101, 1, 1, 1);
    chk("rr_skip", 32'(idx), 2);

    // handshake drop then re-raise
    step(1, 8'h04, 0, 1, 1);
    chk("drop_v", 32'(valid), 0);
    chk("drop_g", 32'(gnt), 0);
    step(1, 8'h04, 0, 1, 0);
    step(1, 8'h04, 1, 1, 0);
    chk("rearm_v", 32'(valid), 1);
    chk("rearm_i", 32'(idx), 2);

    // reset mid-hold with rr pointer at 5
    step(1, 8'h10, 1, 1, 1);
    step(1, 8'h10, 1, 1, 1);
    chk("pre_rst_i", 32'(idx), 4);
    step(0, 8'h30, 1, 1, 0);
    chk("mid_rst_v", 32'(valid), 0);
    step(1, 8'h30, 1, 1, 0);
    chk("post_rst_i", 32'(idx), 4);

    // random traffic against the model
    for (int k = 0; k < 400; k++)
      step(($urandom % 50) != 0, N'($urandom), ($urandom % 4) != 0,
           1'($urandom), 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
